// File: rtl/alu.sv
// Combinational 8-bit R-type ALU with registered zero/negative/carry/overflow flags.
// Define ALU_ALT_EN to enable the alternate op set (SUB/SLL/SRL/SRA) selected by instruction[3].
module alu #(
  parameter int DW = 8,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instruction,
  input  logic [DW-1:0] rs1_data,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] out,
  output logic          flag_z,
  output logic          flag_n,
  output logic          flag_c,
  output logic          flag_v
);

  localparam logic [2:0] OP_R  = 3'b001;
  localparam logic [1:0] R_ADD = 2'b00;
  localparam logic [1:0] R_AND = 2'b01;
  localparam logic [1:0] R_OR  = 2'b10;
  localparam logic [1:0] R_XOR = 2'b11;

  logic [2:0]  opcode;
  logic [1:0]  funct;
  logic        alt_sel;
  logic        is_r;
  logic [DW:0] add_full;
  logic        c_next;
  logic        v_next;

  assign opcode = instruction[2:0];
  assign funct  = instruction[5:4];
  assign is_r   = (opcode == OP_R);

  // Register selects never reach the ALU; the alt bit is dead when the alternate ops are compiled out.
  logic unused_bits;
  assign unused_bits = ^{instruction[IW-1:6], instruction[3]};

  assign add_full = {1'b0, rd_data} + {1'b0, rs1_data};

`ifdef ALU_ALT_EN
  localparam int SHW = $clog2(DW);

  logic [DW:0]    sub_full;
  logic [SHW-1:0] sh;

  assign alt_sel  = instruction[3];
  assign sub_full = {1'b0, rd_data} - {1'b0, rs1_data};
  assign sh       = rs1_data[SHW-1:0];
`else
  assign alt_sel  = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    out    = '0;
    c_next = 1'b0;
    v_next = 1'b0;
    if (is_r) begin
      case ({alt_sel, funct})
        {1'b0, R_ADD}: begin
          out    = add_full[DW-1:0];
          c_next = add_full[DW];
          v_next = (rd_data[DW-1] == rs1_data[DW-1]) && (add_full[DW-1] != rd_data[DW-1]);
        end
        {1'b0, R_AND}: out = rd_data & rs1_data;
        {1'b0, R_OR }: out = rd_data | rs1_data;
        {1'b0, R_XOR}: out = rd_data ^ rs1_data;
`ifdef ALU_ALT_EN
        {1'b1, 2'b00}: begin
          out    = sub_full[DW-1:0];
          // Wrap-around into the extra bit is exactly the unsigned borrow.
          c_next = sub_full[DW];
          v_next = (rd_data[DW-1] != rs1_data[DW-1]) && (sub_full[DW-1] != rd_data[DW-1]);
        end
        {1'b1, 2'b01}: out = rd_data << sh;
        {1'b1, 2'b10}: out = rd_data >> sh;
        {1'b1, 2'b11}: out = $unsigned($signed(rd_data) >>> sh);
`endif
        default: out = '0;
      endcase
    end
  end

  // Flags track the last R-type result; other opcodes leave them untouched.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flags update together at the edge.
    if (rst) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (is_r) begin
      flag_z <= (out == '0);
      flag_n <= out[DW-1];
      flag_c <= c_next;
      flag_v <= v_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: a driver pushes reference-model expectations, a negedge monitor compares.
// Honours ALU_ALT_EN the same way the design does.
module tb_alu;

  logic       clk;
  logic       rst;
  logic [7:0] instruction;
  logic [7:0] rs1_data;
  logic [7:0] rd_data;
  logic [7:0] out;
  logic       flag_z, flag_n, flag_c, flag_v;

  alu #(.DW(8), .IW(8)) dut (
    .clk(clk), .rst(rst), .instruction(instruction),
    .rs1_data(rs1_data), .rd_data(rd_data), .out(out),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] exp_out;
    logic [3:0] exp_flags;  // {z, n, c, v} as seen during this cycle
  } item_t;

  item_t q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic [3:0] model_flags = 4'b0000;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic straight from the operation table.
  task automatic model(input logic [7:0] ins, input logic [7:0] a, input logic [7:0] d,
                       output logic [7:0] o, output logic is_r, output logic [3:0] fl);
    int ua, ud, sa, sd, r, sr, shamt;
    logic c, v;
    ua = int'(a); ud = int'(d);
    sa = (ua > 127) ? ua - 256 : ua;
    sd = (ud > 127) ? ud - 256 : ud;
    shamt = ua % 8;
    r = 0; c = 1'b0; v = 1'b0;
    is_r = (ins[2:0] == 3'b001);
    if (is_r) begin
`ifdef ALU_ALT_EN
      if (ins[3]) begin
        case (ins[5:4])
          2'd0: begin r = ud - ua; sr = sd - sa; c = (ud < ua); v = (sr > 127) || (sr < -128); end
          2'd1: r = ud * (1 << shamt);
          2'd2: r = ud / (1 << shamt);
          default: r = sd >>> shamt;
        endcase
      end else
`endif
      begin
        case (ins[5:4])
          2'd0: begin r = ud + ua; sr = sd + sa; c = (r > 255); v = (sr > 127) || (sr < -128); end
          2'd1: r = ud & ua;
          2'd2: r = ud | ua;
          default: r = ud ^ ua;
        endcase
      end
    end
    o  = 8'(r);
    fl = {(o == 8'h00), o[7], c, v};
  endtask

  // Drives one cycle of stimulus just after a rising edge and records what should be seen.
  task automatic issue(input string name, input logic [7:0] ins, input logic [7:0] a,
                       input logic [7:0] d, input logic r);
    logic [7:0] o;
    logic       is_r;
    logic [3:0] fl;
    item_t      it;
    instruction = ins; rs1_data = a; rd_data = d; rst = r;
    model(ins, a, d, o, is_r, fl);
    it.name = name; it.exp_out = o; it.exp_flags = model_flags;
    q.push_back(it);
    if (r)         model_flags = 4'b0000;
    else if (is_r) model_flags = fl;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle carrying an issued item is checked mid-cycle.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it = q.pop_front();
        check({it.name, " out"}, out, it.exp_out);
        check({it.name, " flags"}, {4'h0, flag_z, flag_n, flag_c, flag_v}, {4'h0, it.exp_flags});
      end
    end
  end

  initial begin
    logic [7:0] ins;
    int waited;
    rst = 1'b1; instruction = 8'h00; rs1_data = 8'h00; rd_data = 8'h00;
    @(posedge clk);
    #1;
    // ADD across all register-select values
    issue("add 00+00", 8'h01, 8'h00, 8'h00, 1'b0);
    issue("add FF+01", 8'h41, 8'h01, 8'hFF, 1'b0);
    issue("add FF+FF", 8'h81, 8'hFF, 8'hFF, 1'b0);
    issue("add 11+22", 8'hC1, 8'h22, 8'h11, 1'b0);
    // logic ops
    issue("and A8,89", 8'h11, 8'hA8, 8'h89, 1'b0);
    issue("or A8,89",  8'h21, 8'hA8, 8'h89, 1'b0);
    issue("xor A8,89", 8'h31, 8'hA8, 8'h89, 1'b0);
    issue("and FF,AA", 8'h11, 8'hFF, 8'hAA, 1'b0);
    issue("or FF,AA",  8'h21, 8'hFF, 8'hAA, 1'b0);
    issue("xor FF,AA", 8'h31, 8'hFF, 8'hAA, 1'b0);
    // overflow, then reset while the same result is still on out
    issue("add 7F+01", 8'h01, 8'h01, 8'h7F, 1'b0);
    issue("rst hold",  8'h01, 8'h01, 8'h7F, 1'b1);
    issue("after rst", 8'h01, 8'h01, 8'h7F, 1'b0);
    // non-R opcode: out 0, flags hold from the carry case
    issue("add FF+01 b", 8'h01, 8'h01, 8'hFF, 1'b0);
    issue("non-R 010", 8'h02, 8'hFF, 8'hFF, 1'b0);
    issue("non-R hold", 8'h06, 8'h12, 8'h34, 1'b0);
    // alt encodings (SUB / SRA when enabled, ADD / XOR otherwise)
    issue("alt sub 05-07", 8'h09, 8'h07, 8'h05, 1'b0);
    issue("alt sra 80>>2", 8'h39, 8'h02, 8'h80, 1'b0);
    issue("alt sll", 8'h19, 8'h03, 8'h81, 1'b0);
    issue("alt srl", 8'h29, 8'h07, 8'h80, 1'b0);
    issue("flags tail", 8'h00, 8'h00, 8'h00, 1'b0);
    // random traffic, mostly R-type with occasional resets
    for (int i = 0; i < 400; i++) begin
      ins = 8'($urandom);
      if ($urandom_range(3) != 0) ins[2:0] = 3'b001;
      issue("rand", ins, 8'($urandom), 8'($urandom), ($urandom_range(19) == 0));
    end
    issue("final", 8'h00, 8'h00, 8'h00, 1'b0);
    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d items left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
